apb_wait_slave: RTL and testbench
=================================

Name: apb_wait_slave

Overview:
- APB2 completer that sits directly downstream of the team's APB master bridge and is driven by one of its two select lines (PSEL1 or PSEL2).
- Contains a DEPTH x 8-bit register-file memory.
- Inserts a programmable number of wait states via PREADY.
- Flags out-of-range addresses and mid-transfer protocol violations on PSLVERR.

Parameters:
- DEPTH, 64: number of 8-bit memory locations, addressed by PADDR[7:0]; legal values 1..256.
- WAIT_STATES, 2: extra ACCESS cycles with PREADY low before completion; legal values 0..15.

Ports:
- PCLK  input  1  clock; all logic is on the rising edge.
- PRESET  input  1  synchronous reset, active-high.
- PSEL  input  1  select from the master's decoder.
- PENABLE  input  1  APB access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  9  address; bit 8 is the master's slave-select bit and is ignored here, bits 7:0 are the word index.
- PWDATA  input  8  write data.
- PRDATA  output  8  read data, registered.
- PREADY  output  1  transfer-complete, registered.
- PSLVERR  output  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1 at a rising edge):
  - state=IDLE.
  - PREADY=0, PSLVERR=0, PRDATA=8'h00.
  - wait counter=0, captured registers=0.
  - All memory words cleared to 8'h00.
  - Reset takes priority over every other event and aborts any transfer in flight; no memory write occurs in that cycle.
- States: IDLE, WAIT, RESP.
- IDLE:
  - PREADY=0.
  - On PSEL=1 and PENABLE=0 (SETUP phase), capture PADDR[7:0], PWRITE and PWDATA, load cnt=WAIT_STATES, go to WAIT.
  - PSEL=1 with PENABLE=1 while in IDLE is ignored (stays IDLE, no response).
- WAIT:
  - If PSEL=0: abort, go to IDLE, no write, no response.
  - If PSEL=1 and PENABLE=1 and cnt!=0: cnt decrements.
  - If PSEL=1 and PENABLE=1 and cnt==0: go to RESP.
  - Error condition, computed at the cnt==0 decision: captured addr >= DEPTH, OR any mismatch between the current PADDR[7:0], PWRITE, PWDATA (PWDATA compared on writes only) and the captured values.
  - No error and write: mem[addr] <= captured PWDATA at this edge.
  - No error and read: PRDATA <= mem[addr].
  - Error: no write, PRDATA <= 8'h00, PSLVERR <= 1.
  - Always at this edge: PREADY <= 1.
- RESP:
  - PREADY=1 for exactly one cycle; PSLVERR valid here.
  - Next edge: PREADY <= 0, PSLVERR <= 0, go to IDLE.
  - PRDATA holds its value until the next read completion or reset.
- Latency: ACCESS phase (PENABLE=1) lasts WAIT_STATES+2 cycles, counted through the cycle where PREADY=1. A back-to-back SETUP issued in the cycle after RESP is accepted normally from IDLE.
- Read-after-write to the same address returns the new data.
- Writes never alter PRDATA.
- Address wrap is not performed: addr >= DEPTH is always an error, never aliased.

Test Plan:
- Reset then read: PRESET high 2 cycles, then read addr 0x005 -> PREADY high on the 4th ACCESS cycle (WAIT_STATES=2), PRDATA=8'h00, PSLVERR=0.
- Write then read: write 8'hA5 to 0x010, then read 0x010 -> each ACCESS lasts 4 cycles, read returns PRDATA=8'hA5, PSLVERR=0. Also read 0x110 (bit 8 ignored) -> 8'hA5.
- Out of range: write 8'h3C to 0x050 (80 >= 64) -> PREADY=1 with PSLVERR=1 for one cycle, then a read of 0x050 also returns PSLVERR=1 with PRDATA=8'h00, and no memory location changes.
- Protocol violation: during ACCESS of a write to 0x002, change PWDATA from 8'h11 to 8'h22 -> PSLVERR=1 at completion and mem[2] keeps its prior value.
- Abort and reset mid-transfer:
  - Drop PSEL in the 2nd ACCESS cycle of a write of 8'h77 to 0x003 -> no PREADY pulse, mem[3] unchanged.
  - Assert PRESET in WAIT -> next cycle state IDLE, all outputs 0.
- Parameter sweep: WAIT_STATES=0 -> PREADY on the 2nd ACCESS cycle. WAIT_STATES=15 -> PREADY on the 17th ACCESS cycle. Back-to-back reads of 0x000 and 0x001 complete with no idle cycle between RESP and the next SETUP.

Source files
------------

// File: rtl/apb_wait_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_wait_slave : APB2 completer, DEPTH x 8 register file, programmable waits
// Revision 1.0
// ---------------------------------------------------------------------------
module apb_wait_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        mem_we;
  logic [7:0]  mem_q [DEPTH];

  logic        w_oor;
  logic        w_mismatch;
  logic        w_err;
  logic [7:0]  w_rd;

  // PADDR[8] selects this slave upstream; it carries no meaning here.
  logic        unused_paddr8;
  assign unused_paddr8 = PADDR[8];

  assign w_oor      = ({1'b0, addr_q} >= 9'(DEPTH));
  assign w_mismatch = (PADDR[7:0] != addr_q) || (PWRITE != write_q) ||
                      (write_q && (PWDATA != wdata_q));
  assign w_err      = w_oor || w_mismatch;
  assign w_rd       = mem_q[addr_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR[7:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d  = S_RESP;
            pready_d = 1'b1;
            if (w_err) begin
              pslverr_d = 1'b1;
              prdata_d  = 8'h00;
            end else if (write_q) begin
              mem_we = 1'b1;
            end else begin
              prdata_d = w_rd;
            end
          end
        end
      end
      S_RESP: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 8'h00;
      write_q   <= 1'b0;
      wdata_q   <= 8'h00;
      prdata_q  <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_wait_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_wait_slave : directed bench for apb_wait_slave (WAIT_STATES 2/0/15)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_apb_wait_slave;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA;

  logic [7:0] rd_w2, rd_w0, rd_w15;
  logic       rdy_w2, rdy_w0, rdy_w15;
  logic       err_w2, err_w0, err_w15;

  logic [7:0] m_rdata;
  logic       m_ready;
  logic       m_err;
  int         sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_wait_slave #(.DEPTH(64), .WAIT_STATES(2)) u_dut_w2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(rd_w2), .PREADY(rdy_w2), .PSLVERR(err_w2)
  );

  apb_wait_slave #(.DEPTH(64), .WAIT_STATES(0)) u_dut_w0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(rd_w0), .PREADY(rdy_w0), .PSLVERR(err_w0)
  );

  apb_wait_slave #(.DEPTH(64), .WAIT_STATES(15)) u_dut_w15 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(rd_w15), .PREADY(rdy_w15), .PSLVERR(err_w15)
  );

  always_comb begin
    m_rdata = rd_w2;
    m_ready = rdy_w2;
    m_err   = err_w2;
    case (sel)
      1: begin m_rdata = rd_w0;  m_ready = rdy_w0;  m_err = err_w0;  end
      2: begin m_rdata = rd_w15; m_ready = rdy_w15; m_err = err_w15; end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // One transfer; ncyc = ACCESS cycle on which PREADY was seen (0 = none, 99 = timeout).
  // chg_at changes PWDATA at the start of that ACCESS cycle; abort_at drops PSEL there.
  task automatic apb_xfer(input logic [8:0] a, input logic w, input logic [7:0] d,
                          input int chg_at, input logic [7:0] chg_d, input int abort_at,
                          output int ncyc, output logic [7:0] rdata, output logic err);
    ncyc = 99; rdata = 8'h00; err = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
    for (int c = 1; c <= 40; c++) begin
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      if (c == chg_at) PWDATA = chg_d;
      if (c == abort_at) begin
        PSEL = 1'b0; PENABLE = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge PCLK);
          if (m_ready) ncyc = c + k;
        end
        return;
      end
      @(negedge PCLK);
      if (m_ready) begin
        ncyc = c; rdata = m_rdata; err = m_err;
        return;
      end
    end
  endtask

  int         n;
  logic [7:0] rd;
  logic       er;
  int         seen;

  initial begin
    sel = 0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 9'h000; PWDATA = 8'h00;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_pready", 32'(m_ready), 32'h0);
    check_eq("rst_pslverr", 32'(m_err), 32'h0);
    check_eq("rst_prdata", 32'(m_rdata), 32'h00);

    apb_xfer(9'h005, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd005_lat", 32'(n), 32'd4);
    check_eq("rd005_data", 32'(rd), 32'h00);
    check_eq("rd005_err", 32'(er), 32'h0);
    bus_idle();

    apb_xfer(9'h010, 1'b1, 8'hA5, 0, 8'h00, 0, n, rd, er);
    check_eq("wr010_lat", 32'(n), 32'd4);
    check_eq("wr010_err", 32'(er), 32'h0);
    bus_idle();
    apb_xfer(9'h010, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd010_lat", 32'(n), 32'd4);
    check_eq("rd010_data", 32'(rd), 32'hA5);
    check_eq("rd010_err", 32'(er), 32'h0);
    bus_idle();
    apb_xfer(9'h110, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd110_data", 32'(rd), 32'hA5);
    check_eq("rd110_err", 32'(er), 32'h0);
    bus_idle();

    // 0x050 would alias onto 0x010 if the address were wrapped.
    apb_xfer(9'h050, 1'b1, 8'h3C, 0, 8'h00, 0, n, rd, er);
    check_eq("wr050_lat", 32'(n), 32'd4);
    check_eq("wr050_err", 32'(er), 32'h1);
    @(negedge PCLK);
    check_eq("wr050_pulse1", 32'(m_ready), 32'h0);
    bus_idle();
    apb_xfer(9'h050, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd050_err", 32'(er), 32'h1);
    check_eq("rd050_data", 32'(rd), 32'h00);
    bus_idle();
    apb_xfer(9'h010, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd010_noalias", 32'(rd), 32'hA5);
    bus_idle();

    apb_xfer(9'h002, 1'b1, 8'h5A, 0, 8'h00, 0, n, rd, er);
    check_eq("wr002_err", 32'(er), 32'h0);
    bus_idle();
    apb_xfer(9'h002, 1'b1, 8'h11, 2, 8'h22, 0, n, rd, er);
    check_eq("viol_lat", 32'(n), 32'd4);
    check_eq("viol_err", 32'(er), 32'h1);
    bus_idle();
    apb_xfer(9'h002, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd002_data", 32'(rd), 32'h5A);
    check_eq("rd002_err", 32'(er), 32'h0);
    bus_idle();

    apb_xfer(9'h003, 1'b1, 8'h77, 0, 8'h00, 2, n, rd, er);
    check_eq("abort_nopready", 32'(n), 32'd0);
    bus_idle();
    apb_xfer(9'h003, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rd003_data", 32'(rd), 32'h00);
    bus_idle();

    apb_xfer(9'h000, 1'b1, 8'h12, 0, 8'h00, 0, n, rd, er);
    bus_idle();
    apb_xfer(9'h001, 1'b1, 8'h34, 0, 8'h00, 0, n, rd, er);
    bus_idle();
    apb_xfer(9'h000, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("b2b0_lat", 32'(n), 32'd4);
    check_eq("b2b0_data", 32'(rd), 32'h12);
    apb_xfer(9'h001, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("b2b1_lat", 32'(n), 32'd4);
    check_eq("b2b1_data", 32'(rd), 32'h34);
    bus_idle();

    apb_xfer(9'h010, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    bus_idle();
    @(negedge PCLK);
    check_eq("pre_rst_prdata", 32'(m_rdata), 32'hA5);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 9'h004; PWRITE = 1'b1; PWDATA = 8'h99;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("midrst_pready", 32'(m_ready), 32'h0);
    check_eq("midrst_pslverr", 32'(m_err), 32'h0);
    check_eq("midrst_prdata", 32'(m_rdata), 32'h00);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      if (m_ready) seen++;
    end
    check_eq("midrst_idle_ignore", 32'(seen), 32'd0);
    bus_idle();
    apb_xfer(9'h010, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rst_cleared010", 32'(rd), 32'h00);
    bus_idle();
    apb_xfer(9'h004, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("rst_nowrite004", 32'(rd), 32'h00);
    bus_idle();

    sel = 1;
    apb_xfer(9'h007, 1'b1, 8'h66, 0, 8'h00, 0, n, rd, er);
    check_eq("w0_wr_lat", 32'(n), 32'd2);
    bus_idle();
    apb_xfer(9'h007, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("w0_rd_lat", 32'(n), 32'd2);
    check_eq("w0_rd_data", 32'(rd), 32'h66);
    bus_idle();

    sel = 2;
    apb_xfer(9'h000, 1'b0, 8'h00, 0, 8'h00, 0, n, rd, er);
    check_eq("w15_rd_lat", 32'(n), 32'd17);
    check_eq("w15_rd_err", 32'(er), 32'h0);
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
